// File: rtl/cotm32_pkg.sv
// cotm32_pkg: shared constants for the multi-hart CLINT (register map offsets, hart limit, XLEN)
package cotm32_pkg;
    localparam int XLEN               = 32;
    localparam int CLINT_MAX_HARTS    = 16;
    localparam int CLINT_OFS_MSIP     = 'h0000;
    localparam int CLINT_OFS_MTIMECMP = 'h4000;
    localparam int CLINT_OFS_PRESC    = 'hBFF0;
    localparam int CLINT_OFS_CTRL     = 'hBFF4;
    localparam int CLINT_OFS_MTIME    = 'hBFF8;
endpackage

// File: rtl/clint_mh_if.sv
// clint_mh_if: peripheral-bus slice seen by the CLINT
//   we    - full-word write strobe
//   addr  - window-relative byte address
//   wdata - write data
//   rdata - combinational read data
interface clint_mh_if #(parameter int ADDR_WIDTH = 16);
    import cotm32_pkg::*;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0]       wdata;
    logic [XLEN-1:0]       rdata;
    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/clint_timebase.sv
// clint_timebase: prescaler, timer enable and the shared 64-bit mtime
//   i_wdata          - bus write data
//   i_presc_we       - write PRESC (also reloads the counter)
//   i_ctrl_we        - write CTRL (bit 0 = enable)
//   i_mtime_lo/hi_we - write one mtime half (suppresses the tick, reloads the counter)
//   o_presc, o_en    - register values for readback
//   o_mtime          - current mtime
//   o_tick           - strobe: mtime increments at this edge
module clint_timebase
    import cotm32_pkg::*;
#(
    parameter int PRESCALER_DEFAULT = 99
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_presc_we,
    input  logic            i_ctrl_we,
    input  logic            i_mtime_lo_we,
    input  logic            i_mtime_hi_we,
    output logic [XLEN-1:0] o_presc,
    output logic            o_en,
    output logic [63:0]     o_mtime,
    output logic            o_tick
);
    logic [XLEN-1:0] r_presc;
    logic [XLEN-1:0] r_pcnt;
    logic            r_en;
    logic [63:0]     r_mtime;
    logic            w_mtime_we;
    logic [63:0]     w_mtime_inc;

    assign w_mtime_we  = i_mtime_lo_we | i_mtime_hi_we;
    assign w_mtime_inc = r_mtime + 64'd1;
    assign o_tick      = r_en && (r_pcnt == '0) && !w_mtime_we;
    assign o_presc     = r_presc;
    assign o_en        = r_en;
    assign o_mtime     = r_mtime;

    // The enable used for counting is the registered one, so a write of
    // CTRL[0]=0 still lets its own cycle count and freezes from the next.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= XLEN'(PRESCALER_DEFAULT);
            r_pcnt  <= XLEN'(PRESCALER_DEFAULT);
            r_en    <= 1'b1;
            r_mtime <= '0;
        end else begin
            if (i_presc_we)
                r_presc <= i_wdata;
            if (i_ctrl_we)
                r_en <= i_wdata[0];
            r_pcnt <= i_presc_we ? i_wdata :
                      w_mtime_we ? r_presc :
                      !r_en ? r_pcnt :
                      (r_pcnt == '0) ? r_presc : r_pcnt - XLEN'(1);
            r_mtime[31:0]  <= i_mtime_lo_we ? i_wdata : o_tick ? w_mtime_inc[31:0]  : r_mtime[31:0];
            r_mtime[63:32] <= i_mtime_hi_we ? i_wdata : o_tick ? w_mtime_inc[63:32] : r_mtime[63:32];
        end
    end
endmodule

// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor (shared mtime, per-hart msip/mtimecmp)
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_bus        - peripheral bus slave (write strobe, byte address, wdata, rdata)
//   o_mtip       - per-hart timer interrupt pending (mtime >= mtimecmp)
//   o_msip       - per-hart software interrupt pending
module clint_mh
    import cotm32_pkg::*;
#(
    parameter int NUM_HARTS         = 2,
    parameter int ADDR_WIDTH        = 16,
    parameter int PRESCALER_DEFAULT = 99
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    clint_mh_if.slave            i_bus,
    output logic [NUM_HARTS-1:0] o_mtip,
    output logic [NUM_HARTS-1:0] o_msip
);
    localparam logic [ADDR_WIDTH-1:0] A_PRESC    = ADDR_WIDTH'(CLINT_OFS_PRESC);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'(CLINT_OFS_CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_MTIME_LO = ADDR_WIDTH'(CLINT_OFS_MTIME);
    localparam logic [ADDR_WIDTH-1:0] A_MTIME_HI = ADDR_WIDTH'(CLINT_OFS_MTIME + 4);

    // All map entries are word aligned, so exact compares also reject
    // misaligned offsets and harts beyond NUM_HARTS.
    function automatic logic [ADDR_WIDTH-1:0] hart_addr(input int base, input int stride, input int h);
        return ADDR_WIDTH'(base + stride * h);
    endfunction

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [XLEN-1:0]       w_rdata;
    logic [XLEN-1:0]       w_presc;
    logic                  w_en;
    logic [63:0]           w_mtime;
    logic                  w_tick_unused;
    logic [NUM_HARTS-1:0]  r_msip;
    logic [63:0]           r_mtimecmp [NUM_HARTS];

    assign w_addr      = i_bus.addr;
    assign i_bus.rdata = w_rdata;

    clint_timebase #(.PRESCALER_DEFAULT(PRESCALER_DEFAULT)) u_timebase (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wdata       (i_bus.wdata),
        .i_presc_we    (i_bus.we && w_addr == A_PRESC),
        .i_ctrl_we     (i_bus.we && w_addr == A_CTRL),
        .i_mtime_lo_we (i_bus.we && w_addr == A_MTIME_LO),
        .i_mtime_hi_we (i_bus.we && w_addr == A_MTIME_HI),
        .o_presc       (w_presc),
        .o_en          (w_en),
        .o_mtime       (w_mtime),
        .o_tick        (w_tick_unused)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_msip <= '0;
            for (int h = 0; h < NUM_HARTS; h++)
                r_mtimecmp[h] <= '1;
        end else if (i_bus.we) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_addr == hart_addr(CLINT_OFS_MSIP, 4, h))
                    r_msip[h] <= i_bus.wdata[0];
                if (w_addr == hart_addr(CLINT_OFS_MTIMECMP, 8, h))
                    r_mtimecmp[h][31:0] <= i_bus.wdata;
                if (w_addr == hart_addr(CLINT_OFS_MTIMECMP + 4, 8, h))
                    r_mtimecmp[h][63:32] <= i_bus.wdata;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_addr == hart_addr(CLINT_OFS_MSIP, 4, h))
                w_rdata = {{(XLEN-1){1'b0}}, r_msip[h]};
            if (w_addr == hart_addr(CLINT_OFS_MTIMECMP, 8, h))
                w_rdata = r_mtimecmp[h][31:0];
            if (w_addr == hart_addr(CLINT_OFS_MTIMECMP + 4, 8, h))
                w_rdata = r_mtimecmp[h][63:32];
        end
        if (w_addr == A_PRESC)
            w_rdata = w_presc;
        if (w_addr == A_CTRL)
            w_rdata = {{(XLEN-1){1'b0}}, w_en};
        if (w_addr == A_MTIME_LO)
            w_rdata = w_mtime[31:0];
        if (w_addr == A_MTIME_HI)
            w_rdata = w_mtime[63:32];
    end

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_mtip
        assign o_mtip[g] = w_mtime >= r_mtimecmp[g];
    end

    assign o_msip = r_msip;
endmodule

// File: tb/tb_clint_mh.sv
// tb_clint_mh: directed plus randomized checks of clint_mh against a register-map reference model
module tb_clint_mh;
    localparam int NH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NH-1:0] mtip;
    logic [NH-1:0] msip;

    clint_mh_if #(.ADDR_WIDTH(16)) bus ();

    clint_mh #(.NUM_HARTS(NH), .ADDR_WIDTH(16), .PRESCALER_DEFAULT(99)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_bus  (bus),
        .o_mtip (mtip),
        .o_msip (msip)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] m_mtime;
    logic [31:0] m_pcnt;
    logic [31:0] m_presc;
    logic        m_en;
    logic [63:0] m_cmp [NH];
    logic [NH-1:0] m_msip;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        int h;
        if (a[1:0] != 2'b00) return 32'd0;
        if (int'(a) < 4 * NH) return {31'd0, m_msip[int'(a) / 4]};
        if (int'(a) >= 'h4000 && int'(a) < 'h4000 + 8 * NH) begin
            h = (int'(a) - 'h4000) / 8;
            return a[2] ? m_cmp[h][63:32] : m_cmp[h][31:0];
        end
        case (a)
            16'hBFF0: return m_presc;
            16'hBFF4: return {31'd0, m_en};
            16'hBFF8: return m_mtime[31:0];
            16'hBFFC: return m_mtime[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [NH-1:0] exp_mtip();
        logic [NH-1:0] r;
        for (int h = 0; h < NH; h++) r[h] = m_mtime >= m_cmp[h];
        return r;
    endfunction

    // One clock edge of the register map as described: counting, ticking, then the write.
    task automatic model_step();
        logic        mw;
        logic [15:0] a;
        logic [31:0] d;
        int          h;
        if (rst) begin
            m_mtime = 64'd0; m_presc = 32'd99; m_pcnt = 32'd99; m_en = 1'b1; m_msip = '0;
            for (int i = 0; i < NH; i++) m_cmp[i] = '1;
            return;
        end
        a = bus.addr;
        d = bus.wdata;
        mw = bus.we && (a == 16'hBFF8 || a == 16'hBFFC);
        if (m_en && !mw) begin
            if (m_pcnt == 0) begin
                m_mtime = m_mtime + 64'd1;
                m_pcnt = m_presc;
            end else begin
                m_pcnt = m_pcnt - 32'd1;
            end
        end
        if (mw) m_pcnt = m_presc;
        if (bus.we && a[1:0] == 2'b00) begin
            if (int'(a) < 4 * NH) m_msip[int'(a) / 4] = d[0];
            else if (int'(a) >= 'h4000 && int'(a) < 'h4000 + 8 * NH) begin
                h = (int'(a) - 'h4000) / 8;
                if (a[2]) m_cmp[h][63:32] = d; else m_cmp[h][31:0] = d;
            end else begin
                case (a)
                    16'hBFF0: begin m_presc = d; m_pcnt = d; end
                    16'hBFF4: m_en = d[0];
                    16'hBFF8: m_mtime[31:0] = d;
                    16'hBFFC: m_mtime[63:32] = d;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("rdata", 64'(bus.rdata), 64'(exp_rd(bus.addr)));
        chk("mtip", 64'(mtip), 64'(exp_mtip()));
        chk("msip", 64'(msip), 64'(m_msip));
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        cyc();
        bus.we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, 64'(bus.rdata), 64'(exp));
    endtask

    logic [15:0] addrs [14] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008, 16'h400C,
                                16'h4010, 16'hBFF0, 16'hBFF4, 16'hBFF8, 16'hBFFC, 16'h0002, 16'h1234};

    initial begin
        logic [63:0] v;
        logic [15:0] a;
        logic [31:0] d;
        bus.we = 1'b0; bus.addr = 16'hBFF8; bus.wdata = 32'd0;
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_mtip", 64'(mtip), 64'd0);
        chk("rst_msip", 64'(msip), 64'd0);
        rd("rst_presc", 16'hBFF0, 32'd99);
        rd("rst_ctrl", 16'hBFF4, 32'd1);
        rd("rst_cmp1_hi", 16'h400C, 32'hFFFF_FFFF);
        rd("rst_mtime_lo", 16'hBFF8, 32'd0);
        repeat (99) cyc();
        rd("idle_99", 16'hBFF8, 32'd0);
        cyc();
        rd("idle_100", 16'hBFF8, 32'd1);
        chk("idle_mtip", 64'(mtip), 64'd0);
        chk("idle_msip", 64'(msip), 64'd0);

        wr(16'hBFF0, 32'd0);
        wr(16'h400C, 32'd0);
        wr(16'h4008, 32'd5);
        bus.addr = 16'hBFF8;
        chk("mtip1_pre", 64'(mtip[1]), 64'd0);
        for (int i = 0; i < 20 && !mtip[1]; i++) cyc();
        chk("mtip1_rise", 64'(mtip[1]), 64'd1);
        rd("mtip1_at5", 16'hBFF8, 32'd5);
        chk("mtip0_low", 64'(mtip[0]), 64'd0);

        wr(16'hBFF8, 32'hFFFF_FFFF);
        wr(16'hBFFC, 32'd0);
        cyc();
        rd("carry_lo", 16'hBFF8, 32'd0);
        rd("carry_hi", 16'hBFFC, 32'd1);
        chk("carry_mtip", 64'(mtip), 64'b10);
        wr(16'hBFFC, 32'hFFFF_FFFF);
        wr(16'hBFF8, 32'hFFFF_FFFF);
        chk("full_mtip", 64'(mtip), 64'b11);
        cyc();
        rd("wrap_lo", 16'hBFF8, 32'd0);
        rd("wrap_hi", 16'hBFFC, 32'd0);
        chk("wrap_mtip", 64'(mtip), 64'd0);

        wr(16'h0004, 32'hFFFF_FFFF);
        chk("msip1_set", 64'(msip), 64'b10);
        rd("msip1_rd", 16'h0004, 32'd1);
        wr(16'h0008, 32'hFFFF_FFFF);
        chk("msip2_ignored", 64'(msip), 64'b10);
        rd("msip2_rd", 16'h0008, 32'd0);
        wr(16'h4010, 32'd7);
        rd("cmp2_rd", 16'h4010, 32'd0);
        rd("misaligned", 16'h0005, 32'd0);

        wr(16'hBFF4, 32'd0);
        v = m_mtime;
        bus.addr = 16'hBFF8;
        repeat (20) cyc();
        rd("frozen", 16'hBFF8, v[31:0]);
        wr(16'hBFF4, 32'd1);
        rd("resume_0", 16'hBFF8, v[31:0]);
        repeat (3) cyc();
        rd("resume_3", 16'hBFF8, v[31:0] + 32'd3);

        wr(16'hBFF0, 32'd3);
        repeat (3) cyc();
        wr(16'hBFF8, 32'h100);
        rd("wr_beats_tick", 16'hBFF8, 32'h100);
        repeat (3) cyc();
        rd("no_tick_yet", 16'hBFF8, 32'h100);
        cyc();
        rd("next_tick", 16'hBFF8, 32'h101);

        rst = 1'b1;
        wr(16'hBFF0, 32'd5);
        rst = 1'b0;
        rd("rst_beats_wr", 16'hBFF0, 32'd99);
        rd("rst_mid_mtime", 16'hBFF8, 32'd0);

        for (int i = 0; i < 500; i++) begin
            a = addrs[$urandom_range(0, 13)];
            if ($urandom_range(0, 3) == 0) begin
                case (a)
                    16'hBFF0: d = $urandom_range(0, 4);
                    16'hBFF4: d = 32'($urandom_range(0, 4) != 0);
                    16'hBFFC, 16'h4004, 16'h400C: d = $urandom_range(0, 1);
                    16'h4000, 16'h4008: d = $urandom_range(0, 300);
                    default: d = $urandom;
                endcase
                wr(a, d);
            end else begin
                bus.addr = a;
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
